uart_tx_arbiter: RTL

Round-robin arbiter that shares one uart_tx transmitter among NUM_REQ byte-stream requesters.
- Grants one requester at a time and keeps the grant for a whole packet (up to the last-flagged byte), bounded by MAX_BURST.
- Sequences uart_tx through its tx_send/tx_busy handshake.
- Recovers from a transmitter that never asserts tx_busy, and from requesters that stall mid-packet.

---
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx among NUM_REQ byte streams.
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   req_data/valid/last   : per-requester byte, valid and end-of-packet flag
//   req_ready             : one-hot accept strobe, only high in CAPTURE
//   tx_data, tx_send      : registered byte and one-cycle start pulse to uart_tx
//   tx_busy               : uart_tx busy from start to stop bit
//   grant_id/grant_active : current or last granted requester, grant held flag
//   err_timeout           : one-cycle pulse when tx_busy never rose after tx_send
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int BUSY_TIMEOUT = 16,
    parameter int HOLD_TIMEOUT = 100000,
    localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_send,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 grant_active,
    output logic                 err_timeout
);
    typedef enum logic [2:0] {IDLE, CAPTURE, SEND, WAIT_HI, WAIT_LO, HOLD} state_t;
    state_t         state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d, gid_q, gid_d, pick, gid_next;
    logic           active_q, active_d, last_q, last_d, found, done, fin, rel;
    logic [7:0]     tx_q, tx_d, burst_q, burst_d;
    logic [31:0]    timer_q, timer_d;

    // Scan downwards so the smallest offset from rr_q wins.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[(int'(rr_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                pick  = IDW'((int'(rr_q) + i) % NUM_REQ);
            end
        end
    end

    // Explicit wrap so non-power-of-2 NUM_REQ stays in range.
    assign gid_next = (int'(gid_q) == NUM_REQ - 1) ? '0 : gid_q + 1'b1;
    assign done     = last_q || (burst_q == 8'(MAX_BURST));

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gid_d       = gid_q;
        active_d    = active_q;
        last_d      = last_q;
        tx_d        = tx_q;
        burst_d     = burst_q;
        timer_d     = '0;
        err_timeout = 1'b0;
        fin         = 1'b0;
        rel         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_busy && found) begin
                    gid_d    = pick;
                    active_d = 1'b1;
                    burst_d  = '0;
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                tx_d    = req_data[8*int'(gid_q) +: 8];
                last_d  = req_last[gid_q];
                burst_d = burst_q + 8'd1;
                state_d = SEND;
            end
            SEND: state_d = WAIT_HI;
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (timer_q == 32'(BUSY_TIMEOUT - 1)) begin
                    err_timeout = 1'b1;
                    fin         = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            WAIT_LO: fin = !tx_busy;
            HOLD: begin
                // Idle timer only runs while the granted requester has nothing to offer.
                if (req_valid[gid_q]) begin
                    timer_d = timer_q;
                    state_d = tx_busy ? HOLD : CAPTURE;
                end else if (timer_q == 32'(HOLD_TIMEOUT - 1)) begin
                    rel = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fin) begin
            rel     = done;
            state_d = done ? IDLE : HOLD;
        end
        if (rel) begin
            active_d = 1'b0;
            rr_d     = gid_next;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            gid_q    <= '0;
            active_q <= 1'b0;
            last_q   <= 1'b0;
            tx_q     <= '0;
            burst_q  <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gid_q    <= gid_d;
            active_q <= active_d;
            last_q   <= last_d;
            tx_q     <= tx_d;
            burst_q  <= burst_d;
            timer_q  <= timer_d;
        end
    end

    assign req_ready    = (state_q == CAPTURE) ? (NUM_REQ'(1) << gid_q) : '0;
    assign tx_send      = (state_q == SEND);
    assign tx_data      = tx_q;
    assign grant_id     = gid_q;
    assign grant_active = active_q;
endmodule
